// File: rtl/pio_sdram_cmd_master.sv
// pio_sdram_cmd_master: PIO-commanded SDRAM write-pattern / read-verify sequencer over Avalon-MM
module pio_sdram_cmd_master #(
  parameter int ADDR_W = 25,
  parameter int LEN_W  = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [31:0]       cmd,
  output logic [ADDR_W-1:0] avm_address,
  output logic              avm_write,
  output logic              avm_read,
  output logic [31:0]       avm_writedata,
  output logic [3:0]        avm_byteenable,
  input  logic              avm_waitrequest,
  input  logic [31:0]       avm_readdata,
  input  logic              avm_readdatavalid,
  output logic              busy,
  output logic              done,
  output logic [15:0]       err_count,
  output logic [15:0]       first_err_idx
);
  typedef enum logic [2:0] {IDLE, WR, RD_REQ, RD_WAIT, DONE} state_t;
  state_t state, state_nx;
  logic go_d, start, xfer, last, mismatch;
  logic [15:0] idx;
  logic [LEN_W:0] remaining;
  logic unused_cmd;
  assign unused_cmd = ^cmd[29:24];
  // Strobes decode straight from the state register so an async reset drops them at once
  assign start = cmd[31] & ~go_d & (state == IDLE || state == DONE);
  assign last = remaining == (LEN_W+1)'(1);
  assign mismatch = avm_readdata != {idx, ~idx};
  assign avm_write = state == WR;
  assign avm_read = state == RD_REQ;
  assign avm_address = ADDR_W'({idx, 2'b00});
  assign avm_writedata = {idx, ~idx};
  assign avm_byteenable = 4'hF;
  // State register
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) state <= IDLE;
    else state <= state_nx;
  // Next state and word-completion strobe
  always_comb begin
    state_nx = state;
    xfer = 1'b0;
    case (state)
      IDLE, DONE: if (start) state_nx = cmd[30] ? WR : RD_REQ;
      WR: begin
        xfer = !avm_waitrequest;
        if (xfer && last) state_nx = DONE;
      end
      RD_REQ: if (!avm_waitrequest) state_nx = RD_WAIT;
      RD_WAIT: begin
        xfer = avm_readdatavalid;
        if (xfer) state_nx = last ? DONE : RD_REQ;
      end
      default: state_nx = IDLE;
    endcase
  end
  // Go edge detect, word index/count and status registers
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      go_d <= 1'b0;
      idx <= '0;
      remaining <= '0;
      busy <= 1'b0;
      done <= 1'b0;
      err_count <= '0;
      first_err_idx <= '0;
    end else begin
      go_d <= cmd[31];
      if (start) begin
        idx <= cmd[15:0];
        remaining <= (LEN_W+1)'(cmd[16 +: LEN_W]) + (LEN_W+1)'(1);
        busy <= 1'b1;
        done <= 1'b0;
        err_count <= '0;
        first_err_idx <= '0;
      end else if (xfer) begin
        idx <= idx + 16'd1;
        remaining <= remaining - (LEN_W+1)'(1);
        if (last) begin
          busy <= 1'b0;
          done <= 1'b1;
        end
        if (state == RD_WAIT && mismatch) begin
          if (err_count != 16'hFFFF) err_count <= err_count + 16'd1;
          if (err_count == 16'h0) first_err_idx <= idx;
        end
      end
    end
endmodule
